constraint_mem_arbiter: RTL

CONSTRAINT_MEM_ARBITER -- requirements
Module: constraint_mem_arbiter

---
 rtl/constraint_mem_arbiter_pkg.sv | 18 +
 rtl/constraint_mem_arbiter_if.sv | 32 +++
 rtl/constraint_mem_arbiter_sync_fifo.sv | 59 +++++
 rtl/constraint_mem_arbiter.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/constraint_mem_arbiter_pkg.sv
// Shared nonogram definitions: board-load states and default BRAM address/word widths,
// imported by the parser, the solver and this arbiter.
package nonogram_pkg;
  localparam int ADDR_W_DEF = 11;
  localparam int DATA_W_DEF = 13;

  typedef enum logic [1:0] {
    LOADING = 2'd0,
    DRAIN   = 2'd1,
    READY   = 2'd2
  } board_state_e;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_WRITE = 2'd1,
    ARB_READ  = 2'd2
  } arb_op_e;
endpackage

// File: rtl/constraint_mem_arbiter_if.sv
// Parser, solver, BRAM and status signals of the constraint memory arbiter.
// The arbiter uses the slave modport; its environment uses the master modport.
interface constraint_mem_arbiter_if import nonogram_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);
  logic              wr_valid;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              board_done;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_gnt;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic [ADDR_W-1:0] bram_addr;
  logic [DATA_W-1:0] bram_din;
  logic              bram_we;
  logic [DATA_W-1:0] bram_dout;
  logic              board_loaded;
  logic              overflow;

  modport master (
    output wr_valid, wr_addr, wr_data, board_done, rd_req, rd_addr, bram_dout,
    input  rd_gnt, rd_valid, rd_data, bram_addr, bram_din, bram_we, board_loaded, overflow
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data, board_done, rd_req, rd_addr, bram_dout,
    output rd_gnt, rd_valid, rd_data, bram_addr, bram_din, bram_we, board_loaded, overflow
  );
endinterface

// File: rtl/constraint_mem_arbiter_sync_fifo.sv
// Synchronous FIFO with a combinational head; a push into a full FIFO succeeds only
// when a pop happens in the same cycle. DEPTH must be a power of two.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end
endmodule

// File: rtl/constraint_mem_arbiter.sv
// Shares one BRAM port between the non-stallable parser (buffered writes) and the solver
// (pipelined reads), with anti-starvation for reads and board-load tracking.
module constraint_mem_arbiter import nonogram_pkg::*; #(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int FIFO_DEPTH = 4,
  parameter int BRAM_LAT   = 2,
  parameter int STARVE_MAX = 4
) (
  input logic                    clk,
  input logic                    rst,
  constraint_mem_arbiter_if.slave bus
);
  localparam int FIFO_W   = ADDR_W + DATA_W;
  localparam int CNT_W    = $clog2(FIFO_DEPTH + 1);
  localparam int STARVE_W = $clog2(STARVE_MAX + 1);

  logic [FIFO_W-1:0]   fifo_head;
  logic                fifo_full;
  logic                fifo_empty;
  logic [CNT_W-1:0]    fifo_count;
  arb_op_e             op;
  logic                rd_grant;
  logic                wr_pop;
  logic                wr_drop;
  logic [STARVE_W-1:0] starve_q, starve_d;
  logic [ADDR_W-1:0]   bram_addr_q, bram_addr_d;
  logic [DATA_W-1:0]   bram_din_q, bram_din_d;
  logic                bram_we_q, bram_we_d;
  logic [BRAM_LAT:0]   rd_pipe_q;
  logic                overflow_q;
  board_state_e        state_q;
  logic                board_loaded_q;

  sync_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_wr_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (bus.wr_valid),
    .pop_i   (wr_pop),
    .din_i   ({bus.wr_addr, bus.wr_data}),
    .dout_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Buffered writes win unless the FIFO is empty or the reader has waited STARVE_MAX writes.
  always_comb begin
    op = ARB_IDLE;
    if (!rst) begin
      if (bus.rd_req && (fifo_empty || (starve_q >= STARVE_W'(STARVE_MAX)))) begin
        op = ARB_READ;
      end else if (!fifo_empty) begin
        op = ARB_WRITE;
      end
    end
  end

  assign rd_grant = (op == ARB_READ);
  assign wr_pop   = (op == ARB_WRITE);
  assign wr_drop  = bus.wr_valid && fifo_full && !wr_pop;

  always_comb begin
    starve_d    = '0;
    bram_addr_d = bram_addr_q;
    bram_din_d  = bram_din_q;
    bram_we_d   = 1'b0;
    case (op)
      ARB_WRITE: begin
        bram_we_d   = 1'b1;
        bram_addr_d = fifo_head[FIFO_W-1 -: ADDR_W];
        bram_din_d  = fifo_head[DATA_W-1:0];
        if (bus.rd_req) begin
          starve_d = starve_q + 1'b1;
        end
      end
      ARB_READ: bram_addr_d = bus.rd_addr;
      default: ;
    endcase
  end

  // The valid pipeline is cleared by reset so grants issued before it never return data.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q    <= '0;
      bram_addr_q <= '0;
      bram_din_q  <= '0;
      bram_we_q   <= 1'b0;
      rd_pipe_q   <= '0;
      overflow_q  <= 1'b0;
    end else begin
      starve_q    <= starve_d;
      bram_addr_q <= bram_addr_d;
      bram_din_q  <= bram_din_d;
      bram_we_q   <= bram_we_d;
      rd_pipe_q   <= {rd_pipe_q[BRAM_LAT-1:0], rd_grant};
      overflow_q  <= overflow_q | wr_drop;
    end
  end

  // Board load tracking; DRAIN waits for the last buffered write to reach the BRAM.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= LOADING;
      board_loaded_q <= 1'b0;
    end else begin
      case (state_q)
        LOADING: begin
          if (bus.board_done) begin
            if ((fifo_count == '0) && !bus.wr_valid) begin
              state_q        <= READY;
              board_loaded_q <= 1'b1;
            end else begin
              state_q <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if ((fifo_count == '0) && !bram_we_q) begin
            state_q        <= READY;
            board_loaded_q <= 1'b1;
          end
        end
        READY: begin
          if (bus.wr_valid) begin
            state_q        <= LOADING;
            board_loaded_q <= 1'b0;
          end
        end
        default: begin
          state_q        <= LOADING;
          board_loaded_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.rd_gnt       = rd_grant;
  assign bus.rd_valid     = rd_pipe_q[BRAM_LAT];
  assign bus.rd_data      = rd_pipe_q[BRAM_LAT] ? bus.bram_dout : '0;
  assign bus.bram_addr    = bram_addr_q;
  assign bus.bram_din     = bram_din_q;
  assign bus.bram_we      = bram_we_q;
  assign bus.board_loaded = board_loaded_q;
  assign bus.overflow     = overflow_q;
endmodule
